lsu: RTL and testbench

Load/store unit for the MEM stage of the RV32I core, directly downstream of the ALU: it takes the ALU result as the effective address and drives a word-wide data-memory port. It handles the memory handshake, byte-lane placement and load sign/zero extension. It also detects misaligned accesses, illegal `funct3` codes and bus timeouts, and holds the pipeline with `stall` until each access completes.

---
 rtl/lsu.sv | 213 +++++++++++++++++++++
 tb/tb_lsu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I MEM-stage load/store unit: bus handshake, lane placement,
// load extension, misalign/illegal-funct3/timeout detection and pipeline stall.
module lsu #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  rsp_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW:0] TO_LIM = TIMEOUT_CYC[CW:0];

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          store_q, store_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          f3_legal;
  logic          misaligned;
  logic [CW:0]   cnt_inc;
  logic          timeout_hit;
  logic [3:0]    be_lat;
  logic [31:0]   wd_lat;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_fmt;

  // Classification looks at the live request; it only steers the IDLE transition.
  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~req_store;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  assign cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == TO_LIM);

  always_comb begin
    be_lat = 4'b0000;
    wd_lat = 32'h0;
    case (f3_q[1:0])
      2'b00: begin
        be_lat = 4'b0001 << addr_q[1:0];
        wd_lat = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_lat = 4'b0011 << addr_q[1:0];
        wd_lat = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be_lat = 4'b1111;
        wd_lat = wdata_q;
      end
      default: begin
        be_lat = 4'b0000;
        wd_lat = 32'h0;
      end
    endcase
    if (!store_q) wd_lat = 32'h0;
  end

  always_comb begin
    rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  rd_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_fmt = {24'h0, rd_shift[7:0]};
      3'b101:  rd_fmt = {16'h0, rd_shift[15:0]};
      default: rd_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cause_d = cause_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (!f3_legal) begin
            state_d = S_DONE;
            cause_d = CAUSE_ILLEGAL;
            rdata_d = 32'h0;
          end else if (misaligned) begin
            state_d = S_DONE;
            cause_d = CAUSE_MISALIGN;
            rdata_d = 32'h0;
          end else begin
            state_d = S_REQ;
            cause_d = CAUSE_NONE;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc[CW-1:0];
        // Acceptance beats a coincident timeout.
        if (mem_ready) begin
          if (store_q) begin
            state_d = S_DONE;
            rdata_d = 32'h0;
          end else begin
            state_d = S_WAIT_R;
          end
        end else if (timeout_hit) begin
          state_d = S_DONE;
          cause_d = CAUSE_TIMEOUT;
          rdata_d = 32'h0;
        end
      end
      S_WAIT_R: begin
        cnt_d = cnt_inc[CW-1:0];
        if (mem_rvalid) begin
          state_d = S_DONE;
          rdata_d = rd_fmt;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          cause_d = CAUSE_TIMEOUT;
          rdata_d = 32'h0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cause_q <= CAUSE_NONE;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs are gated by REQ so idle/reset values are all zero.
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req & store_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? be_lat : 4'b0000;
  assign mem_wdata = mem_req ? wd_lat : 32'h0;

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_err   = rsp_valid && (cause_q != CAUSE_NONE);
  assign rsp_cause = rsp_valid ? cause_q : CAUSE_NONE;
  assign rsp_rdata = rdata_q;
  assign stall     = req_valid && (state_q != S_DONE);

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu with a small bus responder.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  int          o_lat;
  int          o_nreq;
  int          o_stall_bad;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [1:0]  o_cause;
  logic [3:0]  o_be;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic        o_we;
  logic [31:0] last_store;

  lsu #(.TIMEOUT_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_cause  (rsp_cause),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
  // rv_dly < 0 means read data never returns.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int rdy_dly, input int rv_dly,
                           input logic [31:0] rd);
    int acc_cyc;
    bit done;
    acc_cyc = -1;
    done = 0;
    o_lat = -1; o_nreq = 0; o_stall_bad = 0;
    o_rdata = '0; o_err = 0; o_cause = '0;
    o_be = '0; o_addr = '0; o_wdata = '0; o_we = 0;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      mem_rdata  = rd;
      mem_ready  = mem_req && (o_nreq == rdy_dly);
      mem_rvalid = (rv_dly >= 0) && (acc_cyc >= 0) && (cyc == acc_cyc + rv_dly);
      #1;
      if (rsp_valid) begin
        o_lat = cyc; o_rdata = rsp_rdata; o_err = rsp_err; o_cause = rsp_cause;
        if (stall) o_stall_bad++;
        done = 1;
      end else if (!stall) begin
        o_stall_bad++;
      end
      if (mem_req) begin
        o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
        o_nreq++;
        if (mem_ready) begin
          acc_cyc = cyc;
          if (mem_we) last_store = mem_wdata;
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; last_store = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_mem_req", {31'b0, mem_req}, 0);
    check("rst_mem_be", {28'b0, mem_be}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LB 0x1003: byte 3 of 0x80FF1234 is 0x80 -> sign-extended
    do_access(1'b0, 3'b000, 32'h1003, 32'h0, 0, 1, 32'h80FF_1234);
    check("lb_addr", o_addr, 32'h1000);
    check("lb_be", {28'b0, o_be}, 32'h8);
    check("lb_we", {31'b0, o_we}, 0);
    check("lb_rdata", o_rdata, 32'hFFFF_FF80);
    check("lb_lat", o_lat, 3);
    check("lb_err", {31'b0, o_err}, 0);
    check("lb_stall", o_stall_bad, 0);

    // SH 0x102, ready on 4th REQ cycle (coincides with timeout limit 4)
    do_access(1'b1, 3'b001, 32'h102, 32'hDEAD_BEEF, 3, -1, 32'h0);
    check("sh_be", {28'b0, o_be}, 32'hC);
    check("sh_wdata", o_wdata, 32'hBEEF_BEEF);
    check("sh_we", {31'b0, o_we}, 1);
    check("sh_addr", o_addr, 32'h100);
    check("sh_req_cycles", o_nreq, 4);
    check("sh_lat", o_lat, 5);
    check("sh_err", {31'b0, o_err}, 0);
    check("sh_rdata", o_rdata, 0);

    do_access(1'b0, 3'b010, 32'h1001, 32'h0, 0, 1, 32'h5555_5555);
    check("mis_nreq", o_nreq, 0);
    check("mis_lat", o_lat, 1);
    check("mis_err", {31'b0, o_err}, 1);
    check("mis_cause", {30'b0, o_cause}, 1);
    check("mis_rdata", o_rdata, 0);

    // funct3 011 at a misaligned address: illegal wins
    do_access(1'b0, 3'b011, 32'h1001, 32'h0, 0, 1, 32'h5555_5555);
    check("ill_nreq", o_nreq, 0);
    check("ill_lat", o_lat, 1);
    check("ill_cause", {30'b0, o_cause}, 3);

    do_access(1'b1, 3'b100, 32'h0, 32'h1234, 0, -1, 32'h0);
    check("ill_store_cause", {30'b0, o_cause}, 3);

    // Give rsp_rdata a non-zero value before the timeout
    do_access(1'b0, 3'b010, 32'h24, 32'h0, 0, 1, 32'h0BAD_F00D);
    check("lw_rdata", o_rdata, 32'h0BAD_F00D);

    // Timeout: accepted in cycle 1, WAIT_R 2..4, abort into DONE at cycle 5
    do_access(1'b0, 3'b010, 32'h20, 32'h0, 0, -1, 32'h1111_1111);
    check("to_nreq", o_nreq, 1);
    check("to_lat", o_lat, 5);
    check("to_err", {31'b0, o_err}, 1);
    check("to_cause", {30'b0, o_cause}, 2);
    check("to_rdata", o_rdata, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (2) begin
      @(posedge clk); #1;
      check("late_rvalid_rdata", rsp_rdata, 0);
      check("late_rvalid_valid", {31'b0, rsp_valid}, 0);
    end
    mem_rvalid = 1'b0;

    // Reset pulse while in WAIT_R
    req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h40; mem_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 0;
    check("pre_rst_stall", {31'b0, stall}, 1);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check("mid_rst_mem_req", {31'b0, mem_req}, 0);
    check("mid_rst_stall", {31'b0, stall}, 0);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rsp_valid", {31'b0, rsp_valid}, 0);

    do_access(1'b0, 3'b101, 32'h2, 32'h0, 0, 1, 32'h8001_0000);
    check("lhu_rdata", o_rdata, 32'h0000_8001);
    check("lhu_be", {28'b0, o_be}, 32'hC);
    check("lhu_lat", o_lat, 3);

    // Back-to-back SW then LW to the same word; load data comes from the store
    do_access(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 0, -1, 32'h0);
    check("sw_lat", o_lat, 2);
    check("sw_be", {28'b0, o_be}, 32'hF);
    check("sw_wdata", o_wdata, 32'hCAFE_F00D);
    check("sw_stall", o_stall_bad, 0);
    do_access(1'b0, 3'b010, 32'h10, 32'h0, 0, 1, last_store);
    check("lw_b2b_lat", o_lat, 3);
    check("lw_b2b_rdata", o_rdata, 32'hCAFE_F00D);
    check("lw_b2b_stall", o_stall_bad, 0);

    // LH sign extension at upper half
    do_access(1'b0, 3'b001, 32'h6, 32'h0, 0, 1, 32'h9ABC_0000);
    check("lh_rdata", o_rdata, 32'hFFFF_9ABC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
